bas_search_nd: RTL and testbench

Parametrised next-generation Beetle Antennae Search (BAS) optimiser core in fixed point, generalised from the 2-D core to DIM dimensions. The objective function is external, reached through a request/response evaluator handshake, so any fitness unit can be attached. Adds a min/max mode, geometric step decay, saturating coordinate arithmetic and best-so-far (elitist) tracking. It sits between the system controller, which loads a run and waits for done, and a fitness evaluator block.

---
 rtl/bas_search_nd.sv | 222 ++++++++++++++++++++++
 tb/tb_bas_search_nd.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bas_search_nd.sv
// Beetle Antennae Search optimiser core over DIM fixed-point dimensions.
// Fitness comes from an external evaluator via a req/valid handshake; the best point seen is kept.
module bas_search_nd #(
    parameter int DIM         = 2,
    parameter int W           = 16,
    parameter int FIT_W       = 40,
    parameter int ITER_W      = 9,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_maximize,
    input  logic [15:0]          i_seed,
    input  logic [ITER_W-1:0]    i_iterations,
    input  logic [DIM*W-1:0]     i_start_point,
    input  logic [W-1:0]         i_step_init,
    output logic                 o_eval_req,
    output logic [DIM*W-1:0]     o_eval_point,
    input  logic                 i_eval_valid,
    input  logic [FIT_W-1:0]     i_eval_fit,
    output logic [DIM*W-1:0]     o_best_point,
    output logic [FIT_W-1:0]     o_best_fit,
    output logic [ITER_W-1:0]    o_iter_count,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [3:0] {
        IDLE, EVAL_INIT, GEN_DIR, EVAL_L, EVAL_R, MOVE, EVAL_NEW, UPDATE, DONE
    } StateType;

    localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};
    localparam logic [W-1:0]        ONE     = {{(W-1){1'b0}}, 1'b1};

    StateType             r_state;
    logic [15:0]          r_lfsr;
    logic                 r_max;
    logic [ITER_W-1:0]    r_iters;
    logic [ITER_W-1:0]    r_iterCount;
    logic [DIM*W-1:0]     r_x;
    logic [W-1:0]         r_delta;
    logic [W-1:0]         r_antenna;
    logic [DIM-1:0]       r_dir;
    logic [FIT_W-1:0]     r_fitL;
    logic [FIT_W-1:0]     r_fitR;
    logic [DIM*W-1:0]     r_bestPoint;
    logic [FIT_W-1:0]     r_bestFit;
    logic                 r_evalReq;
    logic [DIM*W-1:0]     r_evalPoint;
    logic                 r_busy;
    logic                 r_done;

    logic [15:0]          w_lfsrNext;
    logic [W-1:0]         w_halfDelta;
    logic [W-1:0]         w_deltaDec;
    logic [ITER_W-1:0]    w_iterNext;
    logic [DIM*W-1:0]     w_xl;
    logic [DIM*W-1:0]     w_xr;
    logic [DIM*W-1:0]     w_moveL;
    logic [DIM*W-1:0]     w_moveR;
    logic [DIM*W-1:0]     w_reqPoint;
    logic                 w_inEval;
    logic                 w_accept;

    // Sum is formed two bits wider than W so an unsigned magnitude up to 2^W-1 cannot wrap before clamping.
    function automatic logic [W-1:0] satStep(input logic [W-1:0] base, input logic [W-1:0] mag,
                                             input logic subtract);
        logic signed [W+1:0] ext;
        logic signed [W+1:0] sum;
        ext = $signed({2'b00, mag});
        sum = $signed({{2{base[W-1]}}, base}) + (subtract ? -ext : ext);
        if (sum > SAT_MAX)      satStep = {1'b0, {(W-1){1'b1}}};
        else if (sum < SAT_MIN) satStep = {1'b1, {(W-1){1'b0}}};
        else                    satStep = sum[W-1:0];
    endfunction

    function automatic logic isBetter(input logic [FIT_W-1:0] a, input logic [FIT_W-1:0] b,
                                      input logic maxMode);
        isBetter = maxMode ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
    endfunction

    assign w_lfsrNext  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_halfDelta = r_delta >> 1;
    assign w_deltaDec  = r_delta - (r_delta >> DECAY_SHIFT);
    assign w_iterNext  = r_iterCount + ONE[ITER_W-1:0];
    assign w_inEval    = (r_state == EVAL_INIT) || (r_state == EVAL_L) ||
                         (r_state == EVAL_R) || (r_state == EVAL_NEW);
    assign w_accept    = w_inEval && r_evalReq && i_eval_valid;

    // Candidate points: b_i = +1 when r_dir[i] is set, so "plus b" subtracts when the bit is clear.
    always_comb begin
        w_xl    = '0;
        w_xr    = '0;
        w_moveL = '0;
        w_moveR = '0;
        for (int i = 0; i < DIM; i++) begin
            w_xl[i*W +: W]    = satStep(r_x[i*W +: W], r_antenna, ~r_dir[i]);
            w_xr[i*W +: W]    = satStep(r_x[i*W +: W], r_antenna,  r_dir[i]);
            w_moveL[i*W +: W] = satStep(r_x[i*W +: W], r_delta,   ~r_dir[i]);
            w_moveR[i*W +: W] = satStep(r_x[i*W +: W], r_delta,    r_dir[i]);
        end
    end

    always_comb begin
        w_reqPoint = r_x;
        case (r_state)
            EVAL_L:  w_reqPoint = w_xl;
            EVAL_R:  w_reqPoint = w_xr;
            default: w_reqPoint = r_x;
        endcase
    end

    // Every EVAL state spends its first cycle raising the request; the result is taken on the first valid.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_lfsr      <= 16'h0001;
            r_max       <= 1'b0;
            r_iters     <= '0;
            r_iterCount <= '0;
            r_x         <= '0;
            r_delta     <= '0;
            r_antenna   <= '0;
            r_dir       <= '0;
            r_fitL      <= '0;
            r_fitR      <= '0;
            r_bestPoint <= '0;
            r_bestFit   <= '0;
            r_evalReq   <= 1'b0;
            r_evalPoint <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_load) begin
            r_state     <= EVAL_INIT;
            r_max       <= i_maximize;
            r_lfsr      <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
            r_iters     <= i_iterations;
            r_iterCount <= '0;
            r_x         <= i_start_point;
            r_delta     <= i_step_init;
            r_evalReq   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            if (w_inEval && !r_evalReq) begin
                r_evalReq   <= 1'b1;
                r_evalPoint <= w_reqPoint;
            end
            if (w_accept) r_evalReq <= 1'b0;

            case (r_state)
                EVAL_INIT: if (w_accept) begin
                    r_bestPoint <= r_x;
                    r_bestFit   <= i_eval_fit;
                    if (r_iters == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= GEN_DIR;
                    end
                end
                GEN_DIR: begin
                    r_lfsr    <= w_lfsrNext;
                    r_dir     <= w_lfsrNext[DIM-1:0];
                    r_antenna <= (w_halfDelta == '0) ? ONE : w_halfDelta;
                    r_state   <= EVAL_L;
                end
                EVAL_L: if (w_accept) begin
                    r_fitL  <= i_eval_fit;
                    r_state <= EVAL_R;
                end
                EVAL_R: if (w_accept) begin
                    r_fitR  <= i_eval_fit;
                    r_state <= MOVE;
                end
                MOVE: begin
                    if (isBetter(r_fitL, r_fitR, r_max)) begin
                        r_x     <= w_moveL;
                        r_state <= EVAL_NEW;
                    end else if (isBetter(r_fitR, r_fitL, r_max)) begin
                        r_x     <= w_moveR;
                        r_state <= EVAL_NEW;
                    end else begin
                        r_state <= UPDATE;
                    end
                end
                EVAL_NEW: if (w_accept) begin
                    if (isBetter(i_eval_fit, r_bestFit, r_max)) begin
                        r_bestPoint <= r_x;
                        r_bestFit   <= i_eval_fit;
                    end
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    r_iterCount <= w_iterNext;
                    r_delta     <= (w_deltaDec == '0) ? ONE : w_deltaDec;
                    if (w_iterNext == r_iters) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= GEN_DIR;
                    end
                end
                IDLE, DONE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_eval_req   = r_evalReq;
    assign o_eval_point = r_evalPoint;
    assign o_best_point = r_bestPoint;
    assign o_best_fit   = r_bestFit;
    assign o_iter_count = r_iterCount;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_bas_search_nd.sv
// Directed bench for bas_search_nd with a built-in x^2+y^2 evaluator answering 1-3 cycles after each request.
module tb_bas_search_nd;

    localparam int DIM    = 2;
    localparam int W      = 16;
    localparam int FIT_W  = 40;
    localparam int ITER_W = 9;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 load;
    logic                 maximize;
    logic [15:0]          seed;
    logic [ITER_W-1:0]    iterations;
    logic [DIM*W-1:0]     startPoint;
    logic [W-1:0]         stepInit;
    logic                 evalReq;
    logic [DIM*W-1:0]     evalPoint;
    logic                 evalValid;
    logic [FIT_W-1:0]     evalFit;
    logic [DIM*W-1:0]     bestPoint;
    logic [FIT_W-1:0]     bestFit;
    logic [ITER_W-1:0]    iterCount;
    logic                 busy;
    logic                 done;

    int total = 0;
    int bad   = 0;

    logic [DIM*W-1:0] reqLog [0:31];
    logic [DIM*W-1:0] pendPoint;
    int               reqCount = 0;
    int               waitCnt  = 0;
    int               stallAt  = -1;
    bit               pending  = 1'b0;
    bit               stalled  = 1'b0;

    bas_search_nd #(.DIM(DIM), .W(W), .FIT_W(FIT_W), .ITER_W(ITER_W), .DECAY_SHIFT(4)) dut (
        .i_clock(clock), .i_reset(reset), .i_load(load), .i_maximize(maximize), .i_seed(seed),
        .i_iterations(iterations), .i_start_point(startPoint), .i_step_init(stepInit),
        .o_eval_req(evalReq), .o_eval_point(evalPoint), .i_eval_valid(evalValid), .i_eval_fit(evalFit),
        .o_best_point(bestPoint), .o_best_fit(bestFit), .o_iter_count(iterCount),
        .o_busy(busy), .o_done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [DIM*W-1:0] pt(input logic [15:0] x, input logic [15:0] y);
        return {y, x};
    endfunction

    // Fitness in whole real units: (x^2 + y^2) of Q8.8 coordinates, floored.
    function automatic logic [FIT_W-1:0] fitOf(input logic [DIM*W-1:0] p);
        longint a;
        longint b;
        a = longint'($signed(p[15:0]));
        b = longint'($signed(p[31:16]));
        return FIT_W'((a * a + b * b) >>> 16);
    endfunction

    // One clock step; at the falling edge the bench evaluator observes and answers requests.
    task automatic tick();
        @(negedge clock);
        if (evalValid) begin
            evalValid = 1'b0;
            pending   = 1'b0;
            stalled   = 1'b0;
        end else begin
            if (pending && !evalReq) begin
                pending = 1'b0;
                stalled = 1'b0;
            end
            if (pending && evalReq) begin
                total++;
                if (evalPoint !== pendPoint) begin
                    bad++;
                    $display("[TB] FAIL eval_point_stable: got %h required %h", evalPoint, pendPoint);
                end
            end
            if (evalReq && !pending) begin
                if (reqCount < 32) reqLog[reqCount] = evalPoint;
                pendPoint = evalPoint;
                pending   = 1'b1;
                stalled   = (reqCount == stallAt);
                waitCnt   = reqCount % 3;
                reqCount++;
            end
            if (pending && !stalled) begin
                if (waitCnt == 0) begin
                    evalValid = 1'b1;
                    evalFit   = fitOf(evalPoint);
                end else begin
                    waitCnt--;
                end
            end
        end
    endtask

    task automatic startRun(input logic [DIM*W-1:0] sp, input logic [ITER_W-1:0] its,
                            input logic [W-1:0] st, input logic mx, input logic [15:0] sd);
        startPoint = sp;
        iterations = its;
        stepInit   = st;
        maximize   = mx;
        seed       = sd;
        reqCount   = 0;
        load       = 1'b1;
        tick();
        load       = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL load_starts_run: done=%0b busy=%0b required done=0 busy=1", done, busy);
        end
    endtask

    task automatic waitDone(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_timeout: done=%0b required 1", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b1;
        startRun_inputs();
        tick();
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({evalReq, busy, done, bestFit, bestPoint, iterCount, evalPoint} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: req=%0b busy=%0b done=%0b fit=%h best=%h iter=%0d pt=%h required all 0",
                         evalReq, busy, done, bestFit, bestPoint, iterCount, evalPoint);
            end
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (evalReq !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_idle: req=%0b busy=%0b done=%0b required 0 0 0", evalReq, busy, done);
            end
        end
    endtask

    task automatic startRun_inputs();
        maximize   = 1'b0;
        seed       = 16'h0001;
        iterations = 9'd1;
        startPoint = pt(16'h6500, 16'h7D00);
        stepInit   = 16'h0100;
        evalValid  = 1'b0;
        evalFit    = '0;
    endtask

    task automatic test_iter_zero();
        startRun(pt(16'h6500, 16'h7D00), 9'd0, 16'h0100, 1'b0, 16'h0001);
        waitDone(100, "iter_zero");
        total++;
        if (reqCount !== 1 || reqLog[0] !== pt(16'h6500, 16'h7D00)) begin
            bad++;
            $display("[TB] FAIL iter_zero_requests: count=%0d first=%h required 1 %h",
                     reqCount, reqLog[0], pt(16'h6500, 16'h7D00));
        end
        total++;
        if (bestPoint !== pt(16'h6500, 16'h7D00) || bestFit !== 40'd25826) begin
            bad++;
            $display("[TB] FAIL iter_zero_best: point=%h fit=%0d required %h 25826",
                     bestPoint, bestFit, pt(16'h6500, 16'h7D00));
        end
        total++;
        if (iterCount !== 9'd0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL iter_zero_status: iter=%0d busy=%0b required 0 0", iterCount, busy);
        end
    endtask

    task automatic test_one_iter(input logic mx, input logic [15:0] sd, input logic [DIM*W-1:0] sp,
                                 input logic [DIM*W-1:0] e1, input logic [DIM*W-1:0] e2,
                                 input logic [DIM*W-1:0] e3, input logic [FIT_W-1:0] eFit,
                                 input string name);
        logic [DIM*W-1:0] expReq [0:3];
        expReq[0] = sp;
        expReq[1] = e1;
        expReq[2] = e2;
        expReq[3] = e3;
        startRun(sp, 9'd1, 16'h0100, mx, sd);
        waitDone(200, name);
        total++;
        if (reqCount !== 4) begin
            bad++;
            $display("[TB] FAIL %s_req_count: got %0d required 4", name, reqCount);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (reqLog[i] !== expReq[i]) begin
                bad++;
                $display("[TB] FAIL %s_req%0d: got %h required %h", name, i, reqLog[i], expReq[i]);
            end
        end
        total++;
        if (bestPoint !== e3 || bestFit !== eFit) begin
            bad++;
            $display("[TB] FAIL %s_best: point=%h fit=%0d required %h %0d", name, bestPoint, bestFit, e3, eFit);
        end
        total++;
        if (iterCount !== 9'd1) begin
            bad++;
            $display("[TB] FAIL %s_iter: got %0d required 1", name, iterCount);
        end
    endtask

    task automatic test_abort();
        int n;
        stallAt = 2;
        startRun(pt(16'h6500, 16'h7D00), 9'd1, 16'h0100, 1'b0, 16'h0001);
        n = 0;
        while (reqCount < 3 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (reqCount < 3) begin
            bad++;
            $display("[TB] FAIL abort_reach_eval_r: requests=%0d required 3", reqCount);
        end
        repeat (20) tick();
        total++;
        if (evalReq !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || evalPoint !== pt(16'h6580, 16'h7C80)) begin
            bad++;
            $display("[TB] FAIL abort_stalled: req=%0b busy=%0b done=%0b pt=%h required 1 1 0 %h",
                     evalReq, busy, done, evalPoint, pt(16'h6580, 16'h7C80));
        end
        stallAt    = -1;
        startPoint = pt(16'h0300, 16'h0400);
        iterations = 9'd1;
        stepInit   = 16'h0100;
        maximize   = 1'b0;
        seed       = 16'h0001;
        reqCount   = 0;
        load       = 1'b1;
        evalValid  = 1'b1;
        evalFit    = 40'd0;
        tick();
        load = 1'b0;
        total++;
        if (evalReq !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_drop_req: req=%0b done=%0b required 0 0", evalReq, done);
        end
        waitDone(200, "abort_restart");
        total++;
        if (reqCount !== 4 || reqLog[0] !== pt(16'h0300, 16'h0400) || reqLog[1] !== pt(16'h0280, 16'h0480) ||
            reqLog[2] !== pt(16'h0380, 16'h0380) || reqLog[3] !== pt(16'h0400, 16'h0300)) begin
            bad++;
            $display("[TB] FAIL abort_requests: count=%0d r0=%h r1=%h r2=%h r3=%h required 4 %h %h %h %h",
                     reqCount, reqLog[0], reqLog[1], reqLog[2], reqLog[3], pt(16'h0300, 16'h0400),
                     pt(16'h0280, 16'h0480), pt(16'h0380, 16'h0380), pt(16'h0400, 16'h0300));
        end
        total++;
        if (bestPoint !== pt(16'h0300, 16'h0400) || bestFit !== 40'd25 || iterCount !== 9'd1) begin
            bad++;
            $display("[TB] FAIL abort_best_tie: point=%h fit=%0d iter=%0d required %h 25 1",
                     bestPoint, bestFit, iterCount, pt(16'h0300, 16'h0400));
        end
    endtask

    task automatic test_multi_iter();
        startRun(pt(16'h0A00, 16'hF600), 9'd3, 16'h0200, 1'b0, 16'h1234);
        waitDone(400, "multi_iter");
        total++;
        if (iterCount !== 9'd3 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL multi_iter_count: iter=%0d busy=%0b required 3 0", iterCount, busy);
        end
        total++;
        if (reqCount < 7 || reqCount > 10) begin
            bad++;
            $display("[TB] FAIL multi_iter_requests: got %0d required 7..10", reqCount);
        end
        total++;
        if ($signed(bestFit) > $signed(40'd200)) begin
            bad++;
            $display("[TB] FAIL multi_iter_elitist: fit=%0d required <= 200", bestFit);
        end
    endtask

    initial begin
        test_reset();
        test_iter_zero();
        test_one_iter(1'b0, 16'h0001, pt(16'h6500, 16'h7D00), pt(16'h6480, 16'h7D80),
                      pt(16'h6580, 16'h7C80), pt(16'h6600, 16'h7C00), 40'd25780, "min_one");
        test_one_iter(1'b1, 16'h0001, pt(16'h6500, 16'h7D00), pt(16'h6480, 16'h7D80),
                      pt(16'h6580, 16'h7C80), pt(16'h6400, 16'h7E00), 40'd25876, "max_one");
        test_one_iter(1'b1, 16'h8000, pt(16'h7FC0, 16'h0000), pt(16'h7FFF, 16'hFF80),
                      pt(16'h7F40, 16'h0080), pt(16'h7FFF, 16'hFF00), 40'd16384, "saturate");
        test_abort();
        test_multi_iter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
